// File: rtl/run_sequencer.sv
// run_sequencer: upstream control stage for the 9-bit core.
// Accepts a host run request (four-phase go/finished handshake), latches a
// program ID, drives a START_CYCLES-wide core_start pulse, counts RUN cycles
// until core_done and reports finished/error with the cycle count.
// Optional feature macro: RUN_SEQ_WATCHDOG_EN (RUN watchdog of TIMEOUT cycles).
// All outputs are registered; reset is asynchronous and active-high.
module run_sequencer #(
   parameter int CW           = 16,
   parameter int START_CYCLES = 2,
   parameter int PROGS        = 3,
   parameter int TIMEOUT      = 4095
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          go,
   input  logic [1:0]    prog_sel,
   input  logic          core_done,
   output logic          core_start,
   output logic [1:0]    prog_id,
   output logic          busy,
   output logic          finished,
   output logic          error,
   output logic [CW-1:0] cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Start-pulse down-counter: loaded with START_CYCLES-1, RUN entered at zero.
   localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

   localparam logic [CW-1:0] CNT_MAX     = '1;
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

`ifdef RUN_SEQ_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   // Without the watchdog RUN lasts until core_done; the counter just saturates.
   localparam bit WD_EN = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [SW-1:0] start_cnt_q, start_cnt_d;
   logic [1:0]    prog_id_q, prog_id_d;
   logic [CW-1:0] cycle_count_q, cycle_count_d;
   logic          error_q, error_d;
   logic          core_start_q, core_start_d;
   logic          busy_q, busy_d;
   logic          finished_q, finished_d;

   logic          prog_valid;

   assign prog_valid = (32'(prog_sel) < PROGS);

   // Next-state and next-output computation; outputs are decoded from the
   // next state so that every output comes straight from a flop.
   always_comb begin
      state_d       = state_q;
      start_cnt_d   = start_cnt_q;
      prog_id_d     = prog_id_q;
      cycle_count_d = cycle_count_q;
      error_d       = error_q;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               if (prog_valid) begin
                  prog_id_d     = prog_sel;
                  cycle_count_d = '0;
                  error_d       = 1'b0;
                  start_cnt_d   = SW'(START_CYCLES - 1);
                  state_d       = S_START;
               end else begin
                  // Rejected request: report straight away, core never started.
                  cycle_count_d = '0;
                  error_d       = 1'b1;
                  state_d       = S_DONE;
               end
            end
         end
         S_START: begin
            // core_done is deliberately ignored here: a done left over from
            // the previous run must not terminate the new one.
            if (start_cnt_q == '0) begin
               state_d = S_RUN;
            end else begin
               start_cnt_d = start_cnt_q - SW'(1);
            end
         end
         S_RUN: begin
            if (core_done) begin
               state_d = S_DONE;
               error_d = 1'b0;
            end else if (WD_EN && (cycle_count_q == TIMEOUT_CNT)) begin
               state_d = S_DONE;
               error_d = 1'b1;
            end else if (cycle_count_q != CNT_MAX) begin
               cycle_count_d = cycle_count_q + CW'(1);
            end
         end
         S_DONE: begin
            // Hold results until the host drops go (four-phase return).
            if (!go) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      core_start_d = (state_d == S_START);
      busy_d       = (state_d == S_START) || (state_d == S_RUN);
      finished_d   = (state_d == S_DONE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         start_cnt_q   <= '0;
         prog_id_q     <= '0;
         cycle_count_q <= '0;
         error_q       <= 1'b0;
         core_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         finished_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_cnt_q   <= start_cnt_d;
         prog_id_q     <= prog_id_d;
         cycle_count_q <= cycle_count_d;
         error_q       <= error_d;
         core_start_q  <= core_start_d;
         busy_q        <= busy_d;
         finished_q    <= finished_d;
      end
   end

   assign core_start  = core_start_q;
   assign prog_id     = prog_id_q;
   assign busy        = busy_q;
   assign finished    = finished_q;
   assign error       = error_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer.
// Default build uses CW=4 to exercise counter saturation; with
// RUN_SEQ_WATCHDOG_EN defined it uses CW=8, TIMEOUT=20 to exercise the watchdog.
module tb_run_sequencer;

`ifdef RUN_SEQ_WATCHDOG_EN
   localparam int TB_CW      = 8;
   localparam int TB_TIMEOUT = 20;
`else
   localparam int TB_CW      = 4;
   localparam int TB_TIMEOUT = 4095;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             go;
   logic [1:0]       prog_sel;
   logic             core_done;
   logic             core_start;
   logic [1:0]       prog_id;
   logic             busy;
   logic             finished;
   logic             error;
   logic [TB_CW-1:0] cycle_count;

   int checks = 0;
   int errors = 0;

   run_sequencer #(
      .CW(TB_CW),
      .START_CYCLES(2),
      .PROGS(3),
      .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .go(go),
      .prog_sel(prog_sel),
      .core_done(core_done),
      .core_start(core_start),
      .prog_id(prog_id),
      .busy(busy),
      .finished(finished),
      .error(error),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // One comparison: counts it, asserts, and reports on mismatch.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".core_start"}, 32'(core_start), 0);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".finished"}, 32'(finished), 0);
      chk({tag, ".error"}, 32'(error), 0);
      chk({tag, ".cycle_count"}, 32'(cycle_count), 0);
      chk({tag, ".prog_id"}, 32'(prog_id), 0);
   endtask

   initial begin
      reset = 1'b1; go = 1'b0; prog_sel = 2'd0; core_done = 1'b0;
      #2;
      chk_all_zero("reset");
      tick(); tick();
      reset = 1'b0;
      $display("reset released");

      // ---- Run 1: prog 1, done sampled at RUN edge 8 -> count 7 ----
      go = 1'b1; prog_sel = 2'd1;
      tick();                              // edge 0: accepted
      chk("r1.start_c1", 32'(core_start), 1);
      chk("r1.busy", 32'(busy), 1);
      chk("r1.prog_id", 32'(prog_id), 1);
      chk("r1.finished", 32'(finished), 0);
      prog_sel = 2'd2;                     // must have no effect
      tick();                              // edge 1
      chk("r1.start_c2", 32'(core_start), 1);
      tick();                              // edge 2: into RUN
      chk("r1.start_off", 32'(core_start), 0);
      chk("r1.busy_run", 32'(busy), 1);
      for (int i = 0; i < 7; i++) tick();  // edges 3..9
      chk("r1.count_pre", 32'(cycle_count), 7);
      chk("r1.not_fin", 32'(finished), 0);
      core_done = 1'b1;
      tick();                              // edge 10
      chk("r1.finished", 32'(finished), 1);
      chk("r1.error", 32'(error), 0);
      chk("r1.count", 32'(cycle_count), 7);
      chk("r1.busy_done", 32'(busy), 0);
      chk("r1.prog_id_held", 32'(prog_id), 1);
      tick();                              // go still high: stay in DONE
      chk("r1.fin_hold", 32'(finished), 1);
      go = 1'b0;
      tick();
      chk("r1.fin_drop", 32'(finished), 0);
      chk("r1.idle_busy", 32'(busy), 0);
      $display("run1 done count=%0d", cycle_count);

      // ---- Run 2: stale core_done high through START ----
      go = 1'b1; prog_sel = 2'd0;          // core_done still 1
      tick();
      chk("r2.start", 32'(core_start), 1);
      chk("r2.prog_id", 32'(prog_id), 0);
      chk("r2.count_clr", 32'(cycle_count), 0);
      tick();
      chk("r2.start2", 32'(core_start), 1);
      tick();
      chk("r2.in_run", 32'(busy), 1);
      chk("r2.not_fin", 32'(finished), 0);
      core_done = 1'b0;
      go = 1'b0;                           // dropped during RUN: ignored
      for (int i = 0; i < 3; i++) tick();
      chk("r2.still_run", 32'(busy), 1);
      chk("r2.count_pre", 32'(cycle_count), 3);
      core_done = 1'b1;
      tick();
      chk("r2.finished", 32'(finished), 1);
      chk("r2.count", 32'(cycle_count), 3);
      core_done = 1'b0;
      tick();                              // go already low: one-cycle pulse
      chk("r2.fin_pulse", 32'(finished), 0);
      core_done = 1'b1;                    // done in IDLE is ignored
      tick();
      chk("r2.idle_done_fin", 32'(finished), 0);
      chk("r2.idle_done_busy", 32'(busy), 0);
      core_done = 1'b0;
      $display("run2 done count=%0d", cycle_count);

      // ---- Rejected request: prog_sel=3 ----
      go = 1'b1; prog_sel = 2'd3;
      tick();
      chk("rej.finished", 32'(finished), 1);
      chk("rej.error", 32'(error), 1);
      chk("rej.count", 32'(cycle_count), 0);
      chk("rej.start", 32'(core_start), 0);
      chk("rej.busy", 32'(busy), 0);
      chk("rej.prog_id", 32'(prog_id), 0);
      prog_sel = 2'd1;                     // valid now, but go never toggled
      tick();
      chk("rej.hold_fin", 32'(finished), 1);
      chk("rej.hold_start", 32'(core_start), 0);
      go = 1'b0;
      tick();
      chk("rej.idle", 32'(finished), 0);
      $display("reject done");

      // ---- Run 3: async reset mid-RUN ----
      go = 1'b1; prog_sel = 2'd2;
      tick();
      chk("r3.start", 32'(core_start), 1);
      chk("r3.prog_id", 32'(prog_id), 2);
      chk("r3.error_clr", 32'(error), 0);
      tick(); tick();
      tick(); tick();
      chk("r3.count", 32'(cycle_count), 2);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("arst");
      tick();
      chk("arst.start_held", 32'(core_start), 0);
      #2;
      reset = 1'b0;
      prog_sel = 2'd1;                     // go still high: fresh run
      tick();
      chk("r4.start", 32'(core_start), 1);
      chk("r4.prog_id", 32'(prog_id), 1);
      chk("r4.count0", 32'(cycle_count), 0);
      tick(); tick();
      chk("r4.run_count0", 32'(cycle_count), 0);
      tick();
      chk("r4.count1", 32'(cycle_count), 1);
      $display("run4 started count=%0d", cycle_count);

      for (int i = 0; i < 19; i++) tick();
`ifdef RUN_SEQ_WATCHDOG_EN
      // count reached TIMEOUT=20, still running
      chk("wd.count_pre", 32'(cycle_count), 20);
      chk("wd.busy", 32'(busy), 1);
      tick();
      chk("wd.finished", 32'(finished), 1);
      chk("wd.error", 32'(error), 1);
      chk("wd.count", 32'(cycle_count), 20);
      $display("watchdog run done count=%0d error=%0d", cycle_count, error);
`else
      // 20 increments so far; CW=4 saturates at 15 without a timeout
      chk("sat.count_pre", 32'(cycle_count), 15);
      chk("sat.busy", 32'(busy), 1);
      for (int i = 0; i < 9; i++) tick();  // 29 done=0 RUN edges in total
      chk("sat.still_run", 32'(busy), 1);
      core_done = 1'b1;
      tick();                              // done at RUN cycle 30
      chk("sat.finished", 32'(finished), 1);
      chk("sat.error", 32'(error), 0);
      chk("sat.count", 32'(cycle_count), 15);
      $display("saturation run done count=%0d", cycle_count);
`endif
      core_done = 1'b0;
      go = 1'b0;
      tick();
      chk("end.idle", 32'(finished), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Upstream control stage for the 9-bit core: accepts a run request from the host/bench, latches a program ID, and drives the core's start pulse.
- Consumes the core's done flag and returns a finished/error status with the run's cycle count.
- One run in flight at a time.
- Four-phase go/finished handshake with the host.

Parameters:
- CW, 16: cycle counter width.
- START_CYCLES, 2: width of the core_start pulse in cycles (>=1).
- PROGS, 3: number of valid program IDs; a prog_sel >= PROGS is rejected.
- TIMEOUT, 4095: watchdog limit in RUN cycles; used only with the optional feature.

Ports:
- clk, input, 1: clock. Single clock domain.
- reset, input, 1: asynchronous, active-high reset.
- go, input, 1: host run request (level; four-phase).
- prog_sel, input, 2: program ID, sampled when go is accepted.
- core_done, input, 1: done flag from the core.
- core_start, output, 1: start pulse to the core.
- prog_id, output, 2: latched program ID, held stable from acceptance until the next acceptance.
- busy, output, 1: high in START and RUN.
- finished, output, 1: high in DONE.
- error, output, 1: run rejected or aborted; valid while finished=1.
- cycle_count, output, CW: RUN cycles counted before core_done.

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; core_start, busy, finished, error = 0; cycle_count = 0; prog_id = 0.
- States: IDLE, START, RUN, DONE.
- IDLE:
  - go=1 and prog_sel<PROGS: latch prog_id=prog_sel, clear cycle_count and error, load start counter, go to START.
  - go=1 and prog_sel>=PROGS: prog_id unchanged, cycle_count=0, error=1, go to DONE. core_start is never raised.
  - go=0: stay in IDLE.
- START:
  - core_start=1 for exactly START_CYCLES cycles, then RUN.
  - The first core_start cycle immediately follows the clock edge at which go was sampled (1-cycle latency).
  - core_done is ignored in START; a stale done from the previous run must not end the new run.
- RUN:
  - core_start=0.
  - Each cycle with core_done=0: cycle_count += 1, saturating at 2^CW-1 (no wrap).
  - The cycle in which core_done=1 is sampled: cycle_count unchanged, go to DONE, error=0.
- DONE:
  - finished=1, busy=0; cycle_count, error and prog_id held.
  - go=0: return to IDLE next cycle and deassert finished.
  - go=1: stay in DONE. A new run needs go to fall and rise again (IDLE requires go=0 for at least one cycle after DONE).
- go changes during START or RUN are ignored. If go is already low on entry to DONE, finished is high for exactly one cycle.
- core_done asserted in IDLE or DONE is ignored.
- prog_sel changes outside the IDLE acceptance edge have no effect.
- Reset during RUN: core_start stays 0; the aborted run reports nothing.

Optional Feature:
- RUN_SEQ_WATCHDOG_EN defined:
  - In RUN, if cycle_count == TIMEOUT and core_done=0, go to DONE with error=1 and cycle_count=TIMEOUT.
  - core_done in that same cycle takes priority: error=0.
- RUN_SEQ_WATCHDOG_EN undefined:
  - No timeout; RUN lasts until core_done, with the counter saturating.
  - error is set only by an invalid prog_sel.
  - The TIMEOUT parameter is unused.

Test Plan:
- Reset, then go=1 with prog_sel=1 at edge 0 -> core_start high for cycles 1-2, prog_id=1, busy=1. core_done=1 at cycle 10 -> finished=1, error=0, cycle_count=7. Drop go -> IDLE one cycle later.
- core_done held high from the previous run through START -> ignored; run ends only on a core_done sampled in RUN; count correct.
- prog_sel=3 with PROGS=3 -> core_start never rises, finished=1, error=1, cycle_count=0, prog_id unchanged.
- go dropped during RUN -> finished pulses exactly one cycle after done. go held high in DONE -> finished stays high, no restart until go toggles low then high.
- Async reset asserted mid-RUN (between clock edges) -> all outputs 0 immediately. After release, go=1 starts a clean run from cycle_count=0.
- With RUN_SEQ_WATCHDOG_EN, TIMEOUT=20, core_done never asserted -> DONE with error=1, cycle_count=20. Without the macro, CW=4 and done at RUN cycle 30 -> cycle_count=15 (saturated), error=0.
